// File: rtl/wb_pkg.sv
// Shared defaults, arbitration-mode encodings and a constant-friendly log2
// helper for the writeback arbiter and its channel queues.
package wb_pkg;

  localparam int DEF_NUM_CH     = 3;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_ADDR_W     = 5;
  localparam int DEF_FIFO_DEPTH = 2;

  localparam int RR_MODE_FIXED = 0;
  localparam int RR_MODE_ROUND = 1;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_ROUND = 1'b1
  } arb_mode_e;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int wb_clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/wb_chan_fifo.sv
// Per-channel writeback queue holding (address, data) pairs. Status flags come
// from the registered occupancy count only.
module wb_chan_fifo
  import wb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data
);

  // A single-entry queue still needs a one-bit pointer to index storage.
  localparam int PTR_W = (DEPTH > 1) ? wb_clog2(DEPTH) : 1;
  localparam int CNT_W = wb_clog2(DEPTH + 1);

  logic [ADDR_W-1:0] mem_addr_q [DEPTH];
  logic [ADDR_W-1:0] mem_addr_d [DEPTH];
  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic [DATA_W-1:0] mem_data_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign head_addr = mem_addr_q[rd_ptr_q];
  assign head_data = mem_data_q[rd_ptr_q];

  always_comb begin
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      mem_addr_d[wr_ptr_q] = push_addr;
      mem_data_d[wr_ptr_q] = push_data;
      wr_ptr_d             = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    // A simultaneous push and pop leaves occupancy unchanged.
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_addr_q <= '{default: '0};
      mem_data_q <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges several functional-unit writeback streams into one registered
// register-file write port, one write per cycle, fixed or round-robin priority.
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int RR_MODE    = RR_MODE_FIXED
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            in_valid,
  output logic [NUM_CH-1:0]            in_ready,
  input  logic [NUM_CH-1:0]            in_writereg,
  input  logic [NUM_CH*ADDR_W-1:0]     in_regdest,
  input  logic [NUM_CH*DATA_W-1:0]     in_wbvalue,
  output logic                         wb_reg_en,
  output logic [ADDR_W-1:0]            wb_reg_addr,
  output logic [DATA_W-1:0]            wb_reg_data,
  output logic [wb_clog2(NUM_CH)-1:0]  wb_grant_ch
);

  localparam int CH_W = wb_clog2(NUM_CH);
  localparam arb_mode_e ARB_MODE = (RR_MODE == RR_MODE_ROUND) ? ARB_ROUND : ARB_FIXED;

  logic [NUM_CH-1:0] fifo_full;
  logic [NUM_CH-1:0] fifo_empty;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [ADDR_W-1:0] head_addr [NUM_CH];
  logic [DATA_W-1:0] head_data [NUM_CH];

  logic              grant_found;
  logic [CH_W-1:0]   grant_idx;

  logic              en_q, en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CH_W-1:0]   grant_ch_q, grant_ch_d;
  logic [CH_W-1:0]   last_grant_q, last_grant_d;

  assign in_ready = ~fifo_full;

  // Writes that would not touch the register file are accepted and dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    logic [ADDR_W-1:0] ch_addr;
    assign ch_addr = in_regdest[i*ADDR_W +: ADDR_W];
    assign push[i] = in_valid[i] & ~fifo_full[i] & in_writereg[i] & (ch_addr != '0);

    wb_chan_fifo #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push[i]),
      .pop       (pop[i]),
      .push_addr (ch_addr),
      .push_data (in_wbvalue[i*DATA_W +: DATA_W]),
      .full      (fifo_full[i]),
      .empty     (fifo_empty[i]),
      .head_addr (head_addr[i]),
      .head_data (head_data[i])
    );
  end

  always_comb begin
    int cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int off = 0; off < NUM_CH; off++) begin
      if (ARB_MODE == ARB_ROUND) begin
        cand = (int'(last_grant_q) + 1 + off) % NUM_CH;
      end else begin
        cand = off;
      end
      if (!grant_found && !fifo_empty[cand]) begin
        grant_found = 1'b1;
        grant_idx   = CH_W'(cand);
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pop[i] = grant_found && (grant_idx == CH_W'(i));
    end
  end

  always_comb begin
    en_d         = 1'b0;
    addr_d       = '0;
    data_d       = '0;
    grant_ch_d   = '0;
    last_grant_d = last_grant_q;
    if (grant_found) begin
      en_d         = 1'b1;
      addr_d       = head_addr[grant_idx];
      data_d       = head_data[grant_idx];
      grant_ch_d   = grant_idx;
      last_grant_d = grant_idx;
    end
  end

  // Reset points last_grant at the top channel so round robin starts at ch0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      en_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      grant_ch_q   <= '0;
      last_grant_q <= CH_W'(NUM_CH - 1);
    end else begin
      en_q         <= en_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      grant_ch_q   <= grant_ch_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign wb_reg_en   = en_q;
  assign wb_reg_addr = addr_q;
  assign wb_reg_data = data_q;
  assign wb_grant_ch = grant_ch_q;

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 3: number of functional-unit writeback channels, range 2..8.
REQ-002 SHALL have parameter DATA_W, default 32: writeback data width.
REQ-003 SHALL have parameter ADDR_W, default 5: register address width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 2: entries per channel queue, power of two, range 1..8.
REQ-005 SHALL have parameter RR_MODE, default 0: 0 = fixed priority with ch0 highest; 1 = round robin.
REQ-006 clock  in  1  sole clock; all state changes on its rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 in_valid  in  NUM_CH  per-channel writeback request.
REQ-009 in_ready  out  NUM_CH  per-channel accept; a transfer occurs when in_valid and in_ready are both 1 at a rising edge.
REQ-010 in_writereg  in  NUM_CH  per-channel register-write enable.
REQ-011 in_regdest  in  NUM_CH*ADDR_W  destination addresses; channel i occupies bits [i*ADDR_W +: ADDR_W].
REQ-012 in_wbvalue  in  NUM_CH*DATA_W  writeback values; channel i occupies bits [i*DATA_W +: DATA_W].
REQ-013 wb_reg_en  out  1  registered register-file write enable.
REQ-014 wb_reg_addr  out  ADDR_W  registered write address.
REQ-015 wb_reg_data  out  DATA_W  registered write data.
REQ-016 wb_grant_ch  out  clog2(NUM_CH)  registered index of the channel driving the current write; 0 when wb_reg_en=0.

Function
REQ-017 in_ready[i] SHALL equal "queue i not full", derived from registered state only; there is no same-cycle pass-through when the queue is full.
REQ-018 An accepted request with in_writereg=0 or regdest=0 SHALL be consumed and discarded, occupying no queue slot.
REQ-019 Every other accepted request SHALL be enqueued in channel order and never dropped.
REQ-020 Each cycle the arbiter SHALL grant exactly one non-empty queue, if any exists, pop its head, and register en=1 with that entry's addr, data and channel index.
REQ-021 If all queues are empty, the next outputs SHALL be en=0, addr=0, data=0, grant_ch=0.
REQ-022 Latency: a request accepted into an empty queue at edge k SHALL appear on the outputs after edge k+1 when it wins arbitration.
REQ-023 RR_MODE=0: the lowest-index non-empty queue SHALL win.
REQ-024 RR_MODE=1: the search SHALL start at last_grant+1 modulo NUM_CH; last_grant updates only on a grant.
REQ-025 Simultaneous push and pop on the same queue SHALL keep its occupancy unchanged and preserve FIFO order.
REQ-026 Queue pointers SHALL wrap modulo FIFO_DEPTH; full = (count==FIFO_DEPTH), empty = (count==0).

Reset
REQ-027 While reset=0, all queues SHALL be empty, last_grant = NUM_CH-1, and outputs en=0, addr=0, data=0, grant_ch=0; in_ready SHALL be all ones.
REQ-028 Assertion of reset mid-operation SHALL discard all queued entries, with no write emitted afterwards for them.

Structure
REQ-029 Package wb_pkg SHALL hold the default parameter values, the RR_MODE encodings and the log2 helper.
REQ-030 The per-channel queue SHALL be sub-module wb_chan_fifo, instantiated NUM_CH times through a generate loop; the arbiter and output register SHALL live in the top module.

Verification
REQ-031 Single request: ch1 sends addr=7, data=0xDEADBEEF at edge k -> en=1, addr=7, data=0xDEADBEEF, grant_ch=1 after edge k+1, then en=0.
REQ-032 Fixed priority: ch0, ch1 and ch2 all valid in the same cycle with addr 1, 2, 3 -> writes in order 1, 2, 3 on consecutive cycles, none lost.
REQ-033 Round robin: RR_MODE=1, all channels continuously valid -> grant_ch sequence 0, 1, 2, 0, 1, 2.
REQ-034 Backpressure: FIFO_DEPTH=2, ch2 pushes 3 entries while ch0 saturates -> in_ready[2]=0 on the third push; all 3 ch2 entries are written later in order.
REQ-035 Discard: in_writereg=0, or regdest=0 with data=0x5 -> accepted, no write emitted, and queue occupancy unchanged.
REQ-036 Reset mid-stream: two entries queued, then reset pulsed low -> outputs zero immediately and no write follows release.
